// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b66b frame-alignment controller (block lock).
// Checks each qualified 2-bit sync header coming out of the rx gearbox.
// While alignment is not yet proven, it pulses o_slip to move the gearbox by
// one bit. It declares o_block_lock once a full window of valid headers is seen.
// While locked, it only gives up lock when too many invalid headers land in one
// window.
//
// State table
//   state        | meaning
//   ST_TEST_SH   | counting qualified headers inside the current test window
//   ST_SLIP      | one clock: raise o_slip, bump the slip counter, clear window
//   ST_SLIP_WAIT | gearbox settling after a slip; all headers are ignored
module rx_block_lock #(
    parameter int SH_CNT_MAX       = 64,
    parameter int SH_INVLD_MAX     = 16,
    parameter int SLIP_WAIT_CYCLES = 8,
    parameter int SLIP_CNT_W       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [1:0]            i_header,
    input  logic                  i_header_valid,
    output logic                  o_slip,
    output logic                  o_block_lock,
    output logic [SLIP_CNT_W-1:0] o_slip_count
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX_L   = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0]  INVLD_MAX_L = INV_W'(SH_INVLD_MAX);
    // The wait counter counts down to zero, so loading MAX-1 gives exactly
    // SLIP_WAIT_CYCLES clocks in ST_SLIP_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LOAD_L = WAIT_W'(SLIP_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_TEST_SH   = 2'd0,
        ST_SLIP      = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        sh_cnt_q;
    logic [INV_W-1:0]        sh_invld_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic                    slip_q;
    logic                    lock_q;
    logic [SLIP_CNT_W-1:0]   slip_cnt_q;

    logic                    hdr_bad;
    logic [CNT_W-1:0]        sh_cnt_d;
    logic [INV_W-1:0]        sh_invld_cnt_d;
    logic                    win_done;
    logic                    invld_hit;

    // Header classification and the window counters as they would be after this header.
    always_comb begin
        hdr_bad        = ~(i_header[1] ^ i_header[0]);
        sh_cnt_d       = sh_cnt_q + CNT_W'(1);
        sh_invld_cnt_d = sh_invld_cnt_q + INV_W'(hdr_bad);
        win_done       = (sh_cnt_d == CNT_MAX_L);
        invld_hit      = (sh_invld_cnt_d == INVLD_MAX_L);
    end

    // Block-lock state machine with registered slip, lock and slip count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_TEST_SH;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            wait_cnt_q     <= '0;
            slip_q         <= 1'b0;
            lock_q         <= 1'b0;
            slip_cnt_q     <= '0;
        end else begin
            slip_q <= 1'b0;
            case (state_q)
                ST_TEST_SH: begin
                    if (i_header_valid) begin
                        if (!lock_q) begin
                            // Any invalid header abandons the acquisition window,
                            // even if the same header would have completed it.
                            if (hdr_bad) begin
                                state_q <= ST_SLIP;
                            end else if (win_done) begin
                                lock_q         <= 1'b1;
                                sh_cnt_q       <= '0;
                                sh_invld_cnt_q <= '0;
                            end else begin
                                sh_cnt_q <= sh_cnt_d;
                            end
                        end else begin
                            // Invalid limit is checked before window completion.
                            if (invld_hit) begin
                                lock_q  <= 1'b0;
                                state_q <= ST_SLIP;
                            end else if (win_done) begin
                                sh_cnt_q       <= '0;
                                sh_invld_cnt_q <= '0;
                            end else begin
                                sh_cnt_q       <= sh_cnt_d;
                                sh_invld_cnt_q <= sh_invld_cnt_d;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    slip_q         <= 1'b1;
                    sh_cnt_q       <= '0;
                    sh_invld_cnt_q <= '0;
                    wait_cnt_q     <= WAIT_LOAD_L;
                    if (slip_cnt_q != {SLIP_CNT_W{1'b1}}) begin
                        slip_cnt_q <= slip_cnt_q + SLIP_CNT_W'(1);
                    end
                    state_q <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ST_TEST_SH;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end
                default: begin
                    state_q        <= ST_TEST_SH;
                    sh_cnt_q       <= '0;
                    sh_invld_cnt_q <= '0;
                end
            endcase
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;
    assign o_slip_count = slip_cnt_q;

endmodule
